// File: rtl/tiny_fabric_prog.sv
// tiny_fabric_prog: serial configuration loader for a small array of logic
// clusters. A bitstream frame (sync 0xA5, 8-bit cluster select, 16-bit chain
// length, payload, CRC-8) is shifted into the selected cluster's config chain.
// The cluster is only released to run once the frame's CRC checks out.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   prog_en               session enable; dropping it aborts to IDLE
//   prog_valid, prog_in   serial bitstream, MSB-first per field
//   prog_out              registered readback of cfg_ret[sel]
//   cfg_ret               per-cluster chain tail bits
//   cfg_shift, cfg_data   one-hot chain shift enable and shifted-in bit
//   cluster_run           per-cluster "verified config, may operate"
//   busy, done, err       status; done/err are single-cycle pulses
//   err_code              last error cause: 1 select, 2 length, 3 CRC
module tiny_fabric_prog #(
    parameter int CLUSTERS  = 4,
    parameter int CHAIN_LEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_en,
    input  logic                prog_valid,
    input  logic                prog_in,
    output logic                prog_out,
    input  logic [CLUSTERS-1:0] cfg_ret,
    output logic [CLUSTERS-1:0] cfg_shift,
    output logic                cfg_data,
    output logic [CLUSTERS-1:0] cluster_run,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    localparam int SEL_W  = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1;
    localparam int PCNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [PCNT_W-1:0] LAST_BIT = PCNT_W'(CHAIN_LEN - 1);
    localparam logic [15:0]       LEN_VAL  = 16'(CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE, SYNC, SEL, LEN, LOAD, CRC, COMMIT, ERROR
    } state_e;

    state_e state_q, state_d;

    logic [7:0]          win_q, win_d;
    logic [15:0]         field_q, field_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [7:0]          crc_q, crc_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CLUSTERS-1:0] run_q, run_d;
    logic [1:0]          code_q, code_d;
    logic [CLUSTERS-1:0] shift_q, shift_d;
    logic                data_q, data_d;
    logic                prog_out_q, prog_out_d;

    logic       accept;
    logic [7:0] win_nxt;
    logic [15:0] field_nxt;
    logic [7:0] crc_nxt;

    assign accept    = prog_en & prog_valid;
    assign win_nxt   = {win_q[6:0], prog_in};
    assign field_nxt = {field_q[14:0], prog_in};
    // CRC-8 poly 0x07, MSB-first: feedback is the outgoing top bit xor input
    assign crc_nxt   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ prog_in) ? 8'h07 : 8'h00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; prog_en low overrides everything
    always_comb begin
        state_d = state_q;
        if (!prog_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = SYNC;
                SYNC:   if (accept && win_nxt == 8'hA5) state_d = SEL;
                SEL:    if (accept && fcnt_q == 4'd7)
                            state_d = (field_nxt[7:0] >= 8'(CLUSTERS)) ? ERROR : LEN;
                LEN:    if (accept && fcnt_q == 4'd15)
                            state_d = (field_nxt != LEN_VAL) ? ERROR : LOAD;
                LOAD:   if (accept && pcnt_q == LAST_BIT) state_d = CRC;
                CRC:    if (accept && fcnt_q == 4'd7)
                            state_d = (field_nxt[7:0] != crc_q) ? ERROR : COMMIT;
                COMMIT: state_d = SYNC;
                ERROR:  state_d = SYNC;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        win_d      = '0;
        field_d    = field_q;
        fcnt_d     = fcnt_q;
        pcnt_d     = pcnt_q;
        crc_d      = crc_q;
        sel_d      = sel_q;
        run_d      = run_q;
        code_d     = code_q;
        shift_d    = '0;
        data_d     = data_q;
        prog_out_d = cfg_ret[sel_q];

        // Sync window only lives in SYNC so every search starts clean
        if (state_q == SYNC) begin
            win_d = accept ? win_nxt : win_q;
        end

        if (accept) begin
            case (state_q)
                SEL, LEN, CRC: begin
                    field_d = field_nxt;
                    fcnt_d  = fcnt_q + 4'd1;
                end
                LOAD: begin
                    data_d         = prog_in;
                    shift_d[sel_q] = 1'b1;
                    crc_d          = crc_nxt;
                    pcnt_d         = pcnt_q + PCNT_W'(1);
                end
                default: ;
            endcase
        end

        if (state_d != state_q) begin
            fcnt_d = '0;
            pcnt_d = '0;
        end
        if (state_q == SEL && state_d == LEN) begin
            sel_d = field_nxt[SEL_W-1:0];
        end
        if (state_q == LEN && state_d == LOAD) begin
            crc_d        = '0;
            run_d[sel_q] = 1'b0;
        end
        if (state_q == CRC && state_d == COMMIT) begin
            run_d[sel_q] = 1'b1;
        end
        if (state_d == ERROR && state_q != ERROR) begin
            code_d = (state_q == SEL) ? 2'd1 : (state_q == LEN) ? 2'd2 : 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q      <= '0;
            field_q    <= '0;
            fcnt_q     <= '0;
            pcnt_q     <= '0;
            crc_q      <= '0;
            sel_q      <= '0;
            run_q      <= '0;
            code_q     <= '0;
            shift_q    <= '0;
            data_q     <= 1'b0;
            prog_out_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            field_q    <= field_d;
            fcnt_q     <= fcnt_d;
            pcnt_q     <= pcnt_d;
            crc_q      <= crc_d;
            sel_q      <= sel_d;
            run_q      <= run_d;
            code_q     <= code_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            prog_out_q <= prog_out_d;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = 1'b1;
        done = 1'b0;
        err  = 1'b0;
        case (state_q)
            IDLE, SYNC: busy = 1'b0;
            COMMIT:     done = 1'b1;
            ERROR:      err  = 1'b1;
            default: ;
        endcase
    end

    assign cfg_shift   = shift_q;
    assign cfg_data    = data_q;
    assign cluster_run = run_q;
    assign err_code    = code_q;
    assign prog_out    = prog_out_q;

endmodule

// File: tb/tb_tiny_fabric_prog.sv
// Scoreboard bench for tiny_fabric_prog: frames are driven serially, the
// expected chain shifts and done/err events are queued as stimulus goes out
// and popped by a negedge monitor as the DUT produces them.
module tb_tiny_fabric_prog;
    localparam int CL = 4;
    localparam int CH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_en;
    logic          prog_valid;
    logic          prog_in;
    logic          prog_out;
    logic [CL-1:0] cfg_ret;
    logic [CL-1:0] cfg_shift;
    logic          cfg_data;
    logic [CL-1:0] cluster_run;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    tiny_fabric_prog #(.CLUSTERS(CL), .CHAIN_LEN(CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_en     (prog_en),
        .prog_valid  (prog_valid),
        .prog_in     (prog_in),
        .prog_out    (prog_out),
        .cfg_ret     (cfg_ret),
        .cfg_shift   (cfg_shift),
        .cfg_data    (cfg_data),
        .cluster_run (cluster_run),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [CL:0]   exp_shift_q[$];
    logic [3:0]    exp_evt_q[$];   // {done, err, err_code}
    logic [CL-1:0] run_m = '0;
    int            sel_m = 0;
    logic [CL:0]   mon_s;
    logic [3:0]    mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-8/0x07 as polynomial long division of payload * x^8
    function automatic logic [7:0] crc_ref(input logic [CH-1:0] m);
        logic [8:0] r;
        logic       b;
        r = '0;
        for (int i = 0; i < CH + 8; i++) begin
            b = (i < CH) ? m[CH-1-i] : 1'b0;
            r = {r[7:0], b};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (cfg_shift != '0) begin
            if (exp_shift_q.size() == 0) begin
                chk("shift_unexpected", {cfg_shift, cfg_data}, 0);
            end else begin
                mon_s = exp_shift_q.pop_front();
                chk("shift", {cfg_shift, cfg_data}, mon_s);
            end
        end
        if (done || err) begin
            if (exp_evt_q.size() == 0) begin
                chk("event_unexpected", {done, err}, 0);
            end else begin
                mon_e = exp_evt_q.pop_front();
                chk("event_kind", {done, err}, mon_e[3:2]);
                if (mon_e[2]) chk("event_code", err_code, mon_e[1:0]);
            end
        end
    end

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            repeat ($urandom_range(2, 0)) begin
                prog_valid = 1'b0;
                prog_in    = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        prog_valid = 1'b1;
        prog_in    = b;
        @(posedge clk); #1;
        prog_valid = 1'b0;
    endtask

    task automatic send_field(input logic [31:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    // cut < CH stops after that many payload bits, leaving the DUT mid-LOAD
    task automatic send_frame(input logic [31:0] sync_v, input int sync_n, input int sel,
                              input int len, input logic [CH-1:0] pl, input logic [7:0] crc_x,
                              input bit gap, input int cut);
        logic [CL-1:0] oh;
        logic [7:0]    c;
        send_field(sync_v, sync_n, gap);
        if (sel >= CL) begin
            exp_evt_q.push_back(4'b0101);
            send_field(sel, 8, gap);
            return;
        end
        send_field(sel, 8, gap);
        sel_m = sel;
        chk("busy_in_frame", busy, 1);
        if (len != CH) begin
            exp_evt_q.push_back(4'b0110);
            send_field(len, 16, gap);
            return;
        end
        send_field(len, 16, gap);
        run_m[sel] = 1'b0;
        oh = '0;
        oh[sel] = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (i == cut) return;
            exp_shift_q.push_back({oh, pl[CH-1-i]});
            send_bit(pl[CH-1-i], gap);
        end
        c = crc_ref(pl) ^ crc_x;
        if (crc_x == 8'h00) begin
            exp_evt_q.push_back(4'b1000);
            run_m[sel] = 1'b1;
        end else begin
            exp_evt_q.push_back(4'b0111);
        end
        send_field(c, 8, gap);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        chk("shift_queue_left", exp_shift_q.size(), 0);
        chk("event_queue_left", exp_evt_q.size(), 0);
        chk("cluster_run", cluster_run, run_m);
        chk("busy_after_frame", busy, 0);
    endtask

    task automatic chk_readback(input logic [CL-1:0] r);
        cfg_ret = r;
        repeat (2) @(posedge clk);
        #1;
        chk("prog_out", prog_out, r[sel_m]);
    endtask

    task automatic chk_reset_state();
        chk("rst_cluster_run", cluster_run, 0);
        chk("rst_cfg_shift", cfg_shift, 0);
        chk("rst_cfg_data", cfg_data, 0);
        chk("rst_prog_out", prog_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CH-1:0] p;
        rst_n      = 1'b0;
        prog_en    = 1'b0;
        prog_valid = 1'b0;
        prog_in    = 1'b0;
        cfg_ret    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();

        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_readback(4'b0001);            // select is 0 after reset
        prog_en = 1'b1;
        repeat (2) @(posedge clk); #1;

        // good frame to cluster 2
        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 2, CH, p, 8'h00, 1'b0, CH);
        settle();
        chk_readback(4'b0100);
        chk_readback(4'b1011);

        // same frame, CRC bit 0 flipped
        send_frame(32'hA5, 8, 2, CH, p, 8'h01, 1'b0, CH);
        settle();
        chk("err_code_crc", err_code, 3);

        // bad select, then bad length
        send_frame(32'hA5, 8, 4, CH, p, 8'h00, 1'b0, CH);
        settle();
        chk("err_code_sel", err_code, 1);
        send_frame(32'hA5, 8, 1, 63, p, 8'h00, 1'b0, CH);
        settle();
        chk("err_code_len", err_code, 2);

        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 3, CH, p, 8'h00, 1'b0, CH);
        settle();
        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 1, CH, p, 8'h00, 1'b0, CH);
        settle();

        // abort after 30 payload bits
        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 1, CH, p, 8'h00, 1'b0, 30);
        prog_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_run", cluster_run, run_m);
        @(posedge clk); #1;
        prog_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        send_frame(32'hA5, 8, 1, CH, p, 8'h00, 1'b0, CH);
        settle();

        // noise and overlapping sync prefix, with valid gaps throughout
        p = {$urandom, $urandom};
        send_frame(32'h335A5, 20, 0, CH, p, 8'h00, 1'b1, CH);
        settle();
        chk("err_code_held", err_code, 2);

        // reset for one cycle mid-LOAD
        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 2, CH, p, 8'h00, 1'b0, 10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state();
        run_m = '0;
        sel_m = 0;
        repeat (2) @(posedge clk); #1;
        chk("post_reset_events", exp_evt_q.size(), 0);

        p = {$urandom, $urandom};
        send_frame(32'hA5, 8, 2, CH, p, 8'h00, 1'b0, CH);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
